// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit-arbiter state type.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FRAME_CYCLES = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr+1 and wraps; optional
// strict priority for request 0 when prio0 is high.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               prio0,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic            found;
  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    if (prio0 && req[0]) begin
      found = 1'b1;
    end else begin
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
        cand = ID_W'((32'(ptr) + i) % NUM_REQ);
        if (!found && req[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin front end sharing one UART transmitter between NUM_REQ requesters.
// Optional: define UART_TX_ARB_PRIO0_EN to make requester 0 strict high priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = UART_DATA_W,
  parameter  int FRAME_CYCLES = UART_FRAME_CYCLES,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam int              CNT_W    = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 2);
  localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NUM_REQ - 1);

  arb_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]   win_grant;
  logic                 win_open;
  logic                 accept;
  logic                 prio0;

`ifdef UART_TX_ARB_PRIO0_EN
  assign prio0 = 1'b1;
`else
  assign prio0 = 1'b0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .prio0     (prio0),
    .grant     (win_grant),
    .grant_idx (win_idx)
  );

  // The window reopens one cycle before the frame ends so the next LAUNCH
  // lands exactly FRAME_CYCLES after the previous one.
  always_comb begin
    win_open  = (state == IDLE) || ((state == WAIT) && (cnt == CNT_LAST));
    accept    = win_open && (|win_grant);
    req_ready = (win_open && !RESET) ? win_grant : '0;
    tx_valid  = (state == LAUNCH);
    busy      = (state != IDLE);

    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (cnt == CNT_LAST) state_nxt = accept ? LAUNCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt      <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      rr_ptr   <= PTR_INIT;
    end else begin
      if (state == LAUNCH)    cnt <= '0;
      else if (state == WAIT) cnt <= cnt + 1'b1;

      if (accept) begin
        tx_data  <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id <= win_idx;
`ifdef UART_TX_ARB_PRIO0_EN
        // Priority grants to requester 0 leave the rotation among the rest intact.
        if (win_idx != '0) rr_ptr <= win_idx;
`else
        rr_ptr   <= win_idx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, corner sequences and
// randomized traffic against a timing-based reference model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FC = 10;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  grant_id;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .DATA_W       (DW),
    .FRAME_CYCLES (FC)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame timing from the launch time, winner from a rotating search.
  int         t;
  int         launch_t;
  bit         launched;
  int         last;
  logic [7:0] m_data;
  int         m_gid;
  int         q_launch[$];
  int         q_gid[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endfunction

  function automatic int pick(logic [3:0] v);
`ifdef UART_TX_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    t = 0; launch_t = 0; launched = 0; last = NR - 1;
    m_data = 8'h00; m_gid = 0;
    q_launch.delete(); q_gid.delete();
  endtask

  task automatic do_reset();
    RESET = 1'b1; req_valid = 4'b0000; req_data = 32'h0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d);
    bit         busy_e, win;
    int         w;
    logic [3:0] ready_e;
    req_valid = v; req_data = d;
    @(negedge CLK);
    busy_e  = launched && (t >= launch_t) && (t < launch_t + FC);
    win     = !busy_e || (t == launch_t + FC - 1);
    w       = win ? pick(v) : -1;
    ready_e = (w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(ready_e));
    chk("tx_valid",  32'(tx_valid),  32'(launched && (t == launch_t)));
    chk("busy",      32'(busy),      32'(busy_e));
    chk("tx_data",   32'(tx_data),   32'(m_data));
    chk("grant_id",  32'(grant_id),  32'(m_gid));
    if (tx_valid === 1'b1) begin
      q_launch.push_back(t);
      q_gid.push_back(int'(grant_id));
    end
    if (w >= 0) begin
      launch_t = t + 1; launched = 1;
      m_data = d[w*8 +: 8]; m_gid = w;
`ifdef UART_TX_ARB_PRIO0_EN
      if (w != 0) last = w;
`else
      last = w;
`endif
    end
    @(posedge CLK);
    #1 t++;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  rdy;
    logic        txv;
    logic        bsy;
    logic [7:0]  data;
    logic [1:0]  gid;
  } vec_t;

  function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] r,
                              logic txv, logic bsy, logic [7:0] dat, logic [1:0] g);
    vec_t x;
    x.v = v; x.d = d; x.rdy = r; x.txv = txv; x.bsy = bsy; x.data = dat; x.gid = g;
    return x;
  endfunction

  vec_t tbl[14];

  initial begin
    int exp_gid[7];
    int v_run, len;
    logic [3:0] rv;

    // Single request from requester 2, then a follow-up that exercises the moved pointer.
    tbl[0] = mk(4'b0000, 32'h0,         4'b0000, 1'b0, 1'b0, 8'h00, 2'd0);
    tbl[1] = mk(4'b0100, 32'h00A5_0000, 4'b0100, 1'b0, 1'b0, 8'h00, 2'd0);
    tbl[2] = mk(4'b0000, 32'h0,         4'b0000, 1'b1, 1'b1, 8'hA5, 2'd2);
    for (int unsigned i = 3; i <= 11; i++)
      tbl[i] = mk(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1, 8'hA5, 2'd2);
    tbl[12] = mk(4'b0000, 32'h0,        4'b0000, 1'b0, 1'b0, 8'hA5, 2'd2);
    tbl[13] = mk(4'b0010, 32'h0000_7700, 4'b0010, 1'b0, 1'b0, 8'hA5, 2'd2);

    do_reset();
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_txv",   32'(tx_valid),  32'h0);
    chk("reset_busy",  32'(busy),      32'h0);

    for (int unsigned i = 0; i < 14; i++) begin
      req_valid = tbl[i].v; req_data = tbl[i].d;
      @(negedge CLK);
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy));
      chk("tbl_txv",   32'(tx_valid),  32'(tbl[i].txv));
      chk("tbl_busy",  32'(busy),      32'(tbl[i].bsy));
      chk("tbl_data",  32'(tx_data),   32'(tbl[i].data));
      chk("tbl_gid",   32'(grant_id),  32'(tbl[i].gid));
      @(posedge CLK);
      #1;
    end

    // All requesters continuously valid: rotation and back-to-back period.
    do_reset();
    repeat (42) step(4'b1111, 32'h4332_2110);
    chk("ac_nlaunch", 32'(q_launch.size()), 32'd5);
    if (q_launch.size() == 5) begin
      chk("ac_first", 32'(q_launch[0]), 32'd1);
      for (int k = 0; k < 5; k++) begin
`ifdef UART_TX_ARB_PRIO0_EN
        chk("ac_gid", 32'(q_gid[k]), 32'd0);
`else
        chk("ac_gid", 32'(q_gid[k]), 32'(k % NR));
`endif
        if (k > 0) chk("ac_period", 32'(q_launch[k] - q_launch[k-1]), 32'(FC));
      end
    end

    // Request arriving mid-frame waits for the window.
    do_reset();
    step(4'b0001, 32'h0000_00C3);
    repeat (4) step(4'b0000, 32'h0);
    repeat (7) step(4'b0100, 32'h005A_0000);
    repeat (3) step(4'b0000, 32'h0);
    chk("wt_nlaunch", 32'(q_launch.size()), 32'd2);
    if (q_launch.size() == 2) begin
      chk("wt_period", 32'(q_launch[1] - q_launch[0]), 32'(FC));
      chk("wt_gid",    32'(q_gid[1]), 32'd2);
    end

    // Requester 1 drops out before its turn.
    do_reset();
    step(4'b0001, 32'h0000_0011);
    repeat (2) step(4'b0000, 32'h0);
    repeat (4) step(4'b1010, 32'h3300_2200);
    repeat (6) step(4'b1000, 32'h3300_2200);
    repeat (3) step(4'b0000, 32'h0);
    chk("drop_nlaunch", 32'(q_launch.size()), 32'd2);
    if (q_launch.size() == 2) chk("drop_gid", 32'(q_gid[1]), 32'd3);

    // Reset in the middle of a frame.
    do_reset();
    step(4'b0001, 32'h0000_0077);
    repeat (4) step(4'b0000, 32'h0);
    req_valid = 4'b1111;
    RESET = 1'b1;
    #2;
    chk("mrst_txv",   32'(tx_valid),  32'h0);
    chk("mrst_busy",  32'(busy),      32'h0);
    chk("mrst_ready", 32'(req_ready), 32'h0);
    @(posedge CLK);
    #1;
    chk("mrst_ready2", 32'(req_ready), 32'h0);
    RESET = 1'b0;
    model_reset();
    repeat (3) step(4'b1111, 32'h4433_2211);
    chk("mrst_first", (q_gid.size() > 0) ? 32'(q_gid[0]) : 32'hFFFF_FFFF, 32'd0);

    // Requester 0 held, then released.
    do_reset();
    repeat (31) step(4'b1111, 32'h4332_2110);
    repeat (40) step(4'b1110, 32'h4332_2110);
`ifdef UART_TX_ARB_PRIO0_EN
    exp_gid = '{0, 0, 0, 0, 1, 2, 3};
`else
    exp_gid = '{0, 1, 2, 3, 1, 2, 3};
`endif
    chk("pr_nlaunch", 32'(q_gid.size()), 32'd7);
    if (q_gid.size() == 7)
      for (int k = 0; k < 7; k++) chk("pr_gid", 32'(q_gid[k]), 32'(exp_gid[k]));

    // Randomized traffic with held request patterns of random length.
    do_reset();
    v_run = 0;
    while (v_run < 1000) begin
      rv  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      len = $urandom_range(1, 15);
      for (int k = 0; k < len; k++) step(rv, $urandom);
      v_run += len;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
